// File: rtl/dma_pkg.sv
// Shared types and constants for the OAM DMA sequencer.
package dma_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;

  localparam logic [ADDR_W-1:0] DMA_TRIGGER_ADDR_DEFAULT = 16'h4014;
  localparam logic [ADDR_W-1:0] OAM_DATA_ADDR_DEFAULT    = 16'h2004;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WAIT  = 3'd4,
    WRITE = 3'd5
  } dma_state_e;

endpackage

// File: rtl/oam_dma.sv
// Sprite-memory DMA: copies page XX00-XXFF to the OAM data port while the CPU
// is halted; passes CPU bus traffic through when idle.
module oam_dma
  import dma_pkg::*;
#(
  parameter logic [ADDR_W-1:0] DMA_TRIGGER_ADDR = DMA_TRIGGER_ADDR_DEFAULT,
  parameter logic [ADDR_W-1:0] OAM_DATA_ADDR    = OAM_DATA_ADDR_DEFAULT
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              cycle_tick_i,
  input  logic [ADDR_W-1:0] cpu_address_i,
  input  logic [DATA_W-1:0] cpu_data_i,
  input  logic              cpu_write_i,
  input  logic              cpu_valid_i,
  output logic [DATA_W-1:0] cpu_data_o,
  output logic              cpu_data_valid_o,
  output logic              cpu_halt_o,
  output logic [ADDR_W-1:0] bus_address_o,
  output logic [DATA_W-1:0] bus_data_o,
  output logic              bus_write_o,
  output logic              bus_valid_o,
  input  logic [DATA_W-1:0] bus_data_i,
  input  logic              bus_data_valid_i,
  output logic              busy_o
);

  dma_state_e        r_state;
  dma_state_e        w_state_next;
  logic [DATA_W-1:0] r_page;
  logic [DATA_W-1:0] w_page_next;
  logic [DATA_W-1:0] r_index;
  logic [DATA_W-1:0] w_index_next;
  logic [DATA_W-1:0] r_latch;
  logic [DATA_W-1:0] w_latch_next;
  logic              r_parity;
  logic              r_halt;
  logic              w_halt_next;
  logic              w_tick_even;
  logic              w_tick_odd;
  logic              w_trigger;
  logic              w_idle;

  assign w_idle      = (r_state == IDLE);
  assign w_tick_even = cycle_tick_i & ~r_parity;
  assign w_tick_odd  = cycle_tick_i & r_parity;
  assign w_trigger   = cycle_tick_i & cpu_valid_i & cpu_write_i
                     & (cpu_address_i == DMA_TRIGGER_ADDR);

  // State and datapath registers; reset abandons any transfer in flight.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_state  <= IDLE;
      r_page   <= '0;
      r_index  <= '0;
      r_latch  <= '0;
      r_parity <= 1'b0;
      r_halt   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_page   <= w_page_next;
      r_index  <= w_index_next;
      r_latch  <= w_latch_next;
      r_parity <= r_parity ^ cycle_tick_i;
      r_halt   <= w_halt_next;
    end
  end

  // Next-state: reads on even ticks, writes on odd ticks, late data parks in WAIT.
  always_comb begin
    w_state_next = r_state;
    w_page_next  = r_page;
    w_index_next = r_index;
    w_latch_next = r_latch;
    case (r_state)
      IDLE: begin
        if (w_trigger) begin
          w_page_next  = cpu_data_i;
          w_index_next = '0;
          w_state_next = HALT;
        end
      end
      HALT: begin
        if (cycle_tick_i) begin
          w_state_next = r_parity ? READ : ALIGN;
        end
      end
      ALIGN: begin
        if (cycle_tick_i) begin
          w_state_next = READ;
        end
      end
      READ: begin
        if (w_tick_even) begin
          if (bus_data_valid_i) begin
            w_latch_next = bus_data_i;
            w_state_next = WRITE;
          end else begin
            w_state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (bus_data_valid_i) begin
          w_latch_next = bus_data_i;
          w_state_next = WRITE;
        end
      end
      WRITE: begin
        if (w_tick_odd) begin
          w_index_next = r_index + DATA_W'(1);
          w_state_next = (r_index == {DATA_W{1'b1}}) ? IDLE : READ;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Halt is held for exactly the cycles the sequencer owns the bus.
  assign w_halt_next = (w_state_next != IDLE);

  // Bus mux: CPU pass-through when idle, DMA request on active ticks, else quiet.
  always_comb begin
    bus_address_o = '0;
    bus_data_o    = '0;
    bus_write_o   = 1'b0;
    bus_valid_o   = 1'b0;
    case (r_state)
      IDLE: begin
        bus_address_o = cpu_address_i;
        bus_data_o    = cpu_data_i;
        bus_write_o   = cpu_write_i;
        bus_valid_o   = cpu_valid_i;
      end
      READ: begin
        if (w_tick_even) begin
          bus_address_o = {r_page, r_index};
          bus_valid_o   = 1'b1;
        end
      end
      WRITE: begin
        if (w_tick_odd) begin
          bus_address_o = OAM_DATA_ADDR;
          bus_data_o    = r_latch;
          bus_write_o   = 1'b1;
          bus_valid_o   = 1'b1;
        end
      end
      default: begin
        bus_valid_o = 1'b0;
      end
    endcase
  end

  // Read return path to the CPU only exists while idle.
  assign cpu_data_o       = w_idle ? bus_data_i : '0;
  assign cpu_data_valid_o = w_idle & bus_data_valid_i;
  assign cpu_halt_o       = r_halt;
  assign busy_o           = ~w_idle;

endmodule
